// File: rtl/io_bus_bridge.sv
// rtl/io_bus_bridge.sv - Avalon-MM slave to io_* handshake bus master bridge
//
// Purpose: accepts one Avalon-MM read or write at a time. It presents the
// request on the io_* bus with SETUP_CYC cycles of address/data setup. It
// raises io_bus_enable until the synchronised io_acknowledge is seen, returns
// a single waitrequest-low cycle, and then waits for the acknowledge to drop
// before accepting the next request.
//
// Optional feature: define IO_BRIDGE_TIMEOUT_EN to bound the STROBE and RELEASE
// waits to TIMEOUT_CYC cycles. A timed-out read returns all ones, and
// timeout_err pulses for one cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   avs_*                 Avalon-MM slave (word address, readdata registered)
//   irq                   io_irq after a 2-flop synchroniser
//   timeout_err           one-cycle pulse on STROBE/RELEASE timeout
//   io_acknowledge/io_irq asynchronous inputs from the io slave
//   io_address .. io_write_data  registered io bus master outputs
//   io_read_data          read data, stable while io_acknowledge is high
module io_bus_bridge #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT_CYC = 255,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [BE_W-1:0]   avs_byteenable,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              irq,
  output logic              timeout_err,
  input  logic              io_acknowledge,
  input  logic              io_irq,
  output logic [ADDR_W-1:0] io_address,
  output logic              io_bus_enable,
  output logic [BE_W-1:0]   io_byte_enable,
  output logic              io_rw,
  output logic [DATA_W-1:0] io_write_data,
  input  logic [DATA_W-1:0] io_read_data
);

  // Setup counter is sized to at least one bit so SETUP_CYC of 0 or 1 still elaborates.
  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam logic [SW-1:0] SETUP_LAST = SW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ack_sync_q, irq_sync_q;
  logic              ack_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rw_q, rw_d;
  logic              en_q, en_d;
  logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              terr_q, terr_d;
`endif

  assign ack_s = ack_sync_q[1];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rw_d        = rw_q;
    setup_cnt_d = setup_cnt_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
    tcnt_d      = tcnt_q + 1'b1;
    terr_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (avs_read | avs_write) begin
          addr_d      = avs_address;
          be_d        = avs_byteenable;
          wdata_d     = avs_writedata;
          rw_d        = avs_read;  // read wins when both are asserted
          setup_cnt_d = '0;
          state_d     = (SETUP_CYC == 0) ? S_STROBE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) state_d = S_STROBE;
        else                           setup_cnt_d = setup_cnt_q + 1'b1;
      end
      S_STROBE: begin
        if (ack_s) begin
          if (rw_q) rdata_d = io_read_data;
          state_d = S_DONE;
        end
`ifdef IO_BRIDGE_TIMEOUT_EN
        else if (tcnt_q == T_LAST) begin
          if (rw_q) rdata_d = '1;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: state_d = S_RELEASE;
      S_RELEASE: begin
        if (!ack_s) state_d = S_IDLE;
`ifdef IO_BRIDGE_TIMEOUT_EN
        else if (tcnt_q == T_LAST) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Registered strobe: high exactly for the cycles spent in STROBE.
    en_d = (state_d == S_STROBE);
`ifdef IO_BRIDGE_TIMEOUT_EN
    if (state_d != state_q) tcnt_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ack_sync_q  <= '0;
      irq_sync_q  <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rw_q        <= 1'b0;
      en_q        <= 1'b0;
      setup_cnt_q <= '0;
`ifdef IO_BRIDGE_TIMEOUT_EN
      tcnt_q      <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ack_sync_q  <= {ack_sync_q[0], io_acknowledge};
      irq_sync_q  <= {irq_sync_q[0], io_irq};
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rw_q        <= rw_d;
      en_q        <= en_d;
      setup_cnt_q <= setup_cnt_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      terr_q      <= terr_d;
`endif
    end
  end

  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = (state_q != S_DONE);
  assign irq             = irq_sync_q[1];
  assign io_address      = addr_q;
  assign io_bus_enable   = en_q;
  assign io_byte_enable  = be_q;
  assign io_rw           = rw_q;
  assign io_write_data   = wdata_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
  assign timeout_err     = terr_q;
`else
  assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb/tb_io_bus_bridge.sv - self-checking bench for io_bus_bridge
module tb_io_bus_bridge;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_read, a_write, a_wait, a_irq, a_terr, a_ack, a_io_irq, a_io_en, a_io_rw;
  logic [15:0] a_addr, a_wdata, a_rdata, a_io_addr, a_io_wdata, a_io_rdata;
  logic [1:0]  a_be, a_io_be;
  logic        ack_mode, ack_man;
  assign a_ack = ack_mode ? ack_man : a_io_en;

  // Instance B: SETUP_CYC=3, TIMEOUT_CYC=8
  logic        b_read, b_write, b_wait, b_irq, b_terr, b_ack, b_io_irq, b_io_en, b_io_rw;
  logic [15:0] b_addr, b_wdata, b_rdata, b_io_addr, b_io_wdata, b_io_rdata;
  logic [1:0]  b_be, b_io_be;
  logic        b_ack_en;
  assign b_ack = b_ack_en & b_io_en;

  io_bus_bridge u_a (
    .clk(clk), .reset_n(reset_n),
    .avs_address(a_addr), .avs_read(a_read), .avs_write(a_write),
    .avs_writedata(a_wdata), .avs_byteenable(a_be), .avs_readdata(a_rdata),
    .avs_waitrequest(a_wait), .irq(a_irq), .timeout_err(a_terr),
    .io_acknowledge(a_ack), .io_irq(a_io_irq), .io_address(a_io_addr),
    .io_bus_enable(a_io_en), .io_byte_enable(a_io_be), .io_rw(a_io_rw),
    .io_write_data(a_io_wdata), .io_read_data(a_io_rdata)
  );

  io_bus_bridge #(.SETUP_CYC(3), .TIMEOUT_CYC(8)) u_b (
    .clk(clk), .reset_n(reset_n),
    .avs_address(b_addr), .avs_read(b_read), .avs_write(b_write),
    .avs_writedata(b_wdata), .avs_byteenable(b_be), .avs_readdata(b_rdata),
    .avs_waitrequest(b_wait), .irq(b_irq), .timeout_err(b_terr),
    .io_acknowledge(b_ack), .io_irq(b_io_irq), .io_address(b_io_addr),
    .io_bus_enable(b_io_en), .io_byte_enable(b_io_be), .io_rw(b_io_rw),
    .io_write_data(b_io_wdata), .io_read_data(b_io_rdata)
  );

  int n_chk = 0;
  int n_err = 0;
  int ta_cnt = 0;

  always @(negedge clk) if (a_terr) ta_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
    logic        exp_rw;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [5];

  // Runs one transfer on instance A with the io slave acking on io_bus_enable.
  task automatic xfer(input vec_t v, output int done_c, output int en_first, output int en_cnt);
    done_c = -1; en_first = -1; en_cnt = 0;
    a_io_rdata = v.rdata; a_addr = v.addr; a_wdata = v.wdata; a_be = v.be;
    a_read = v.rd; a_write = v.wr;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (a_io_en) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
      end
      if (!a_wait) begin
        done_c = c;
        break;
      end
    end
    a_read = 1'b0; a_write = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int d, ef, ec, en_c, d1, e2, d2, lows, ens, ok, bf, bd, n, tc, tfirst;

    vt[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 16'hBEEF, 1'b1, 16'hBEEF};
    vt[1] = '{1'b0, 1'b1, 16'h0123, 16'h1234, 2'b10, 16'h5555, 1'b0, 16'hBEEF};
    vt[2] = '{1'b1, 1'b1, 16'hFFFF, 16'hAAAA, 2'b11, 16'h0001, 1'b1, 16'h0001};
    vt[3] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'b01, 16'h0000, 1'b1, 16'h0000};
    vt[4] = '{1'b0, 1'b1, 16'h8001, 16'hFFFF, 2'b01, 16'h1111, 1'b0, 16'h0000};

    reset_n = 1'b0;
    a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_io_irq = 0; a_io_rdata = 0;
    b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_be = 0; b_io_irq = 0; b_io_rdata = 0;
    ack_mode = 0; ack_man = 0; b_ack_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_wait", a_wait, 1);
    chk("rst_en", a_io_en, 0);
    chk("rst_addr", a_io_addr, 0);
    chk("rst_rw", a_io_rw, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_irq", a_irq, 0);
    chk("rst_terr", a_terr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      xfer(vt[i], d, ef, ec);
      chk($sformatf("v%0d_done", i), d, 5);
      chk($sformatf("v%0d_en_first", i), ef, 2);
      chk($sformatf("v%0d_en_cnt", i), ec, 3);
      chk($sformatf("v%0d_rw", i), a_io_rw, vt[i].exp_rw);
      chk($sformatf("v%0d_addr", i), a_io_addr, vt[i].addr);
      chk($sformatf("v%0d_wdata", i), a_io_wdata, vt[i].wdata);
      chk($sformatf("v%0d_be", i), a_io_be, vt[i].be);
      chk($sformatf("v%0d_rdata", i), a_rdata, vt[i].exp_rd);
    end

    // SETUP_CYC=3 write on instance B
    b_addr = 16'h0007; b_wdata = 16'h1234; b_be = 2'b10; b_write = 1;
    ok = 0; bf = -1; bd = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (b_io_en && bf < 0) bf = c;
      if (bf < 0 && !b_io_rw && b_io_wdata == 16'h1234 && b_io_be == 2'b10 && b_io_addr == 16'h0007) ok++;
      if (!b_wait) begin
        bd = c;
        break;
      end
    end
    b_write = 0;
    chk("b_setup_cycles", ok, 3);
    chk("b_en_first", bf, 4);
    chk("b_done", bd, 7);
    chk("b_rdata_kept", b_rdata, 16'h0000);
    repeat (5) @(negedge clk);

    // Delayed ack, held after strobe falls, with a back-to-back second read
    ack_mode = 1; ack_man = 0; a_io_rdata = 16'h0A0A; a_addr = 16'h0100; a_read = 1;
    en_c = -1; d1 = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (a_io_en && en_c < 0) en_c = c;
      if (en_c >= 0 && c == en_c + 20) ack_man = 1;
      if (!a_wait) begin
        d1 = c;
        break;
      end
    end
    chk("dly_en_first", en_c, 2);
    chk("dly_done", d1, 25);
    chk("dly_rdata", a_rdata, 16'h0A0A);
    a_addr = 16'h0200; a_io_rdata = 16'h5A5A;
    e2 = -1; d2 = -1;
    for (int c = 26; c <= 100; c++) begin
      @(negedge clk);
      if (c == 30) ack_man = 0;
      if (a_io_en && e2 < 0) begin
        e2 = c;
        ack_mode = 0;
      end
      if (!a_wait && e2 >= 0) begin
        d2 = c;
        break;
      end
    end
    a_read = 0;
    chk("b2b_en_first", e2, 35);
    chk("b2b_done", d2, 38);
    chk("b2b_addr", a_io_addr, 16'h0200);
    chk("b2b_rdata", a_rdata, 16'h5A5A);
    repeat (5) @(negedge clk);

    // Reset asserted mid-STROBE
    ack_mode = 1; ack_man = 0; a_addr = 16'h0300; a_read = 1;
    repeat (3) @(negedge clk);
    chk("mid_en_before", a_io_en, 1);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_en", a_io_en, 0);
    chk("mid_rst_wait", a_wait, 1);
    chk("mid_rst_rdata", a_rdata, 0);
    @(negedge clk);
    reset_n = 1; a_read = 0; ack_mode = 0;
    lows = 0; ens = 0;
    repeat (10) begin
      @(negedge clk);
      if (!a_wait) lows++;
      if (a_io_en) ens++;
    end
    chk("post_rst_no_done", lows, 0);
    chk("post_rst_no_en", ens, 0);
    xfer(vt[0], d, ef, ec);
    chk("post_rst_done", d, 5);
    chk("post_rst_rdata", a_rdata, 16'hBEEF);

    // irq synchroniser latency
    @(negedge clk);
    #3 a_io_irq = 1;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (a_irq && n == 0) n = k;
    end
    chk("irq_rise_edges", n, 2);
    @(negedge clk);
    #2 a_io_irq = 0;
    n = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (!a_irq && n == 0) n = k;
    end
    chk("irq_fall_edges", n, 2);

`ifdef IO_BRIDGE_TIMEOUT_EN
    // Read with no ack on instance B times out after 8 STROBE cycles
    @(negedge clk);
    b_ack_en = 0; b_addr = 16'h0055; b_io_rdata = 16'h1234; b_read = 1;
    bd = -1; tc = 0; tfirst = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (b_terr) begin
        tc++;
        if (tfirst < 0) tfirst = c;
      end
      if (!b_wait && bd < 0) begin
        bd = c;
        b_read = 0;
      end
    end
    b_read = 0;
    chk("to_done", bd, 12);
    chk("to_rdata", b_rdata, 16'hFFFF);
    chk("to_err_cnt", tc, 1);
    chk("to_err_cycle", tfirst, 12);
`else
    tc = 0; tfirst = 0;
`endif

    chk("a_terr_never", ta_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
